hslp_dot_acc: RTL and testbench
===============================

# hslp_dot_acc

Streaming dot-product accumulator that sits directly downstream of the 8x8 approximate multiplier and consumes its 16-bit unsigned product stream. It sums one packet of products, delimited by a last flag, into a saturating accumulator and presents the packet sum on a valid/ready output port. It is the reduction stage that turns per-pair approximate products into inner-product results for error-resilient workloads.

## Interface
- ACC_W, 24, accumulator/sum width; legal range 16..32.
- CNT_W, 8, term-counter width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- clear  in  1  synchronous flush: drop any packet in progress and return to IDLE.
- p_valid  in  1  product beat valid.
- p_ready  out  1  accumulator can take a beat.
- prod  in  16  unsigned product from the multiplier.
- p_last  in  1  beat is the final term of the packet.
- o_valid  out  1  packet result valid.
- o_ready  in  1  consumer takes result.
- sum  out  ACC_W  saturated packet sum.
- terms  out  CNT_W  number of beats in the packet; saturates at all-ones.
- sat  out  1  the packet saturated at least once.

## Operation
- States: IDLE (no partial sum), ACC (partial sum held), HOLD (result presented).
- Beat accepted when p_valid && p_ready; p_ready = 1 in IDLE/ACC, 0 in HOLD.
- Accepted beat in IDLE: acc <= zero-extended prod; cnt <= 1; sat_r <= 0.
- Accepted beat in ACC: acc <= sat_add(acc, prod); cnt <= cnt+1, saturating at 2^CNT_W-1; sat_r |= carry-out.
- sat_add: the ACC_W+1 bit sum clamps to 2^ACC_W-1 on overflow; once clamped the value stays clamped.
- Accepted beat with p_last=1: go to HOLD regardless of the current state. A single-beat packet is legal.
- Accepted beat with p_last=0: go to ACC.
- In HOLD: o_valid=1. sum, terms and sat are stable until o_valid && o_ready; then go to IDLE.
- clear=1 has priority over every other event: go to IDLE, zero acc/cnt/sat_r, o_valid=0, and discard any beat or result handshake in that cycle.
- p_valid without p_ready: the producer holds the beat; the block imposes no requirement on it.

## Timing
- Reset values: p_ready=0 while rst_n low and 1 from the first edge after release; o_valid=0; sum=0; terms=0; sat=0; state IDLE.
- Latency: the last beat accepted at edge N gives o_valid=1 after edge N (visible in cycle N+1).
- Throughput: one beat per cycle inside a packet.
- After the result handshake at edge M, the next beat can be accepted at edge M+1, so there is one bubble per packet.
- All outputs are registered; no combinational path from p_valid/prod to any output.
- p_ready depends only on registered state, never combinationally on o_ready.
- rst_n asserted mid-packet or in HOLD: immediate return to reset values; the partial sum is lost.

## Structure
- Shared package hslp_pkg holds:
  - state enum (IDLE/ACC/HOLD);
  - PROD_W=16 constant;
  - default ACC_W/CNT_W constants, shared with the multiplier wrappers.
- One sub-module: hslp_sat_add.
  - Parameterised ACC_W saturating unsigned adder: acc + zero-extended 16-bit operand → result, ovf.
  - Purely combinational; reused by later accumulating stages.
- Top level: FSM, counter, output registers.

## Test plan
- Reset then packet {100, 200, 300, last}, o_ready=1 → one cycle after last: sum=600, terms=3, sat=0; o_valid for exactly one cycle.
- Single beat prod=65025 with p_last, o_ready=0 for 5 cycles → p_ready=0 and sum=65025, terms=1 held stable 5 cycles; handshake then p_ready=1 next cycle.
- ACC_W=17, three beats of 65025 → sum=131071, sat=1, terms=3.
- 256 beats of 65025 with default widths → sum=16646400, sat=0, terms=255 (counter saturated).
- clear asserted mid-packet after {10, 20}, then packet {5, last} → sum=5, terms=1; no result is emitted for the aborted packet.
- rst_n pulsed low while in HOLD → o_valid drops asynchronously and all outputs are 0. A back-to-back packet after reset yields a correct independent sum.

Source files
------------

// File: rtl/hslp_pkg.sv
// Shared definitions for the hslp approximate-multiply datapath: product width,
// default accumulator/counter widths and the dot-accumulator state encoding.
package hslp_pkg;

  localparam int PROD_W    = 16;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/hslp_dot_acc_if.sv
// Product-stream input and packet-result output of the dot accumulator.
// The slave modport is the accumulator side; the master modport is its environment.
interface hslp_dot_acc_if
  import hslp_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic              p_valid;
  logic              p_ready;
  logic [PROD_W-1:0] prod;
  logic              p_last;
  logic              o_valid;
  logic              o_ready;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  terms;
  logic              sat;

  modport slave (
    input  p_valid, prod, p_last, o_ready,
    output p_ready, o_valid, sum, terms, sat
  );

  modport master (
    output p_valid, prod, p_last, o_ready,
    input  p_ready, o_valid, sum, terms, sat
  );

endinterface

// File: rtl/hslp_sat_add.sv
// Combinational saturating unsigned adder: ACC_W accumulator plus a zero-extended
// product; an all-ones accumulator stays clamped.
module hslp_sat_add
  import hslp_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] add_i,
  output logic [ACC_W-1:0]  res_o,
  output logic              ovf_o
);

  logic [ACC_W:0] wide_s;

  // Widened sum; the extra bit is the carry-out that triggers the clamp.
  always_comb begin
    wide_s = {1'b0, acc_i} + (ACC_W+1)'(add_i);
    ovf_o  = wide_s[ACC_W];
    if (wide_s[ACC_W]) begin
      res_o = {ACC_W{1'b1}};
    end else begin
      res_o = wide_s[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/hslp_dot_acc.sv
// Streaming dot-product accumulator: sums one p_last-delimited packet of products
// into a saturating accumulator and presents the result on a valid/ready port.
module hslp_dot_acc
  import hslp_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  hslp_dot_acc_if.slave  bus
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             rdy_q, o_valid_q;

  logic [ACC_W-1:0] add_res_s;
  logic             add_ovf_s;
  logic             beat_s;
  logic             done_s;

  hslp_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc_i (acc_q),
    .add_i (bus.prod),
    .res_o (add_res_s),
    .ovf_o (add_ovf_s)
  );

  assign beat_s = bus.p_valid && rdy_q;
  assign done_s = o_valid_q && bus.o_ready;

  // Next-state and datapath update; clear overrides any beat or result handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = ST_IDLE;
      acc_d   = {ACC_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (beat_s) begin
            if (state_q == ST_IDLE) begin
              acc_d = ACC_W'(bus.prod);
              cnt_d = CNT_W'(1);
              sat_d = 1'b0;
            end else begin
              acc_d = add_res_s;
              cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
              sat_d = sat_q | add_ovf_s;
            end
            state_d = bus.p_last ? ST_HOLD : ST_ACC;
          end else begin
            state_d = state_q;
          end
        end
        ST_HOLD: begin
          if (done_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, datapath and handshake registers; p_ready stays low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= {ACC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      sat_q     <= 1'b0;
      rdy_q     <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      rdy_q     <= (state_d != ST_HOLD);
      o_valid_q <= (state_d == ST_HOLD);
    end
  end

  assign bus.p_ready = rdy_q;
  assign bus.o_valid = o_valid_q;
  assign bus.sum     = acc_q;
  assign bus.terms   = cnt_q;
  assign bus.sat     = sat_q;

endmodule

// File: tb/tb_hslp_dot_acc.sv
// Directed self-checking bench for hslp_dot_acc: default-width instance plus an
// ACC_W=17 instance used to exercise saturation.
module tb_hslp_dot_acc;

  logic clk;
  logic rst_n;
  logic clear;
  int   errors;
  int   checks;

  hslp_dot_acc_if #(.ACC_W(24), .CNT_W(8)) bus ();
  hslp_dot_acc_if #(.ACC_W(17), .CNT_W(8)) b17 ();

  hslp_dot_acc #(.ACC_W(24), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  hslp_dot_acc #(.ACC_W(17), .CNT_W(8)) dut17 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (b17.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and waits (bounded) until it is accepted.
  task automatic send_beat(input bit use17, input logic [15:0] p, input logic last);
    bit taken;
    taken = 1'b0;
    if (use17) begin
      b17.p_valid = 1'b1; b17.prod = p; b17.p_last = last;
    end else begin
      bus.p_valid = 1'b1; bus.prod = p; bus.p_last = last;
    end
    for (int i = 0; i < 20 && !taken; i++) begin
      taken = use17 ? b17.p_ready : bus.p_ready;
      tick();
    end
    bus.p_valid = 1'b0;
    b17.p_valid = 1'b0;
    if (!taken) begin
      checks++; errors++;
      $display("FAIL beat_accept: beat %0d not accepted within 20 cycles", p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++; if (bus.p_ready !== 1'b0) begin errors++; $display("FAIL rst_p_ready: got %b expected 0", bus.p_ready); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.sum !== 24'd0) begin errors++; $display("FAIL rst_sum: got %0d expected 0", bus.sum); end
    checks++; if (bus.terms !== 8'd0) begin errors++; $display("FAIL rst_terms: got %0d expected 0", bus.terms); end
    checks++; if (bus.sat !== 1'b0) begin errors++; $display("FAIL rst_sat: got %b expected 0", bus.sat); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.p_ready !== 1'b1) begin errors++; $display("FAIL rst_release_p_ready: got %b expected 1", bus.p_ready); end
  endtask

  task automatic test_basic();
    bus.o_ready = 1'b1;
    send_beat(1'b0, 16'd100, 1'b0);
    send_beat(1'b0, 16'd200, 1'b0);
    send_beat(1'b0, 16'd300, 1'b1);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL basic_o_valid: got %b expected 1", bus.o_valid); end
    checks++; if (bus.sum !== 24'd600) begin errors++; $display("FAIL basic_sum: got %0d expected 600", bus.sum); end
    checks++; if (bus.terms !== 8'd3) begin errors++; $display("FAIL basic_terms: got %0d expected 3", bus.terms); end
    checks++; if (bus.sat !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b expected 0", bus.sat); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL basic_o_valid_pulse: got %b expected 0", bus.o_valid); end
  endtask

  task automatic test_hold();
    bus.o_ready = 1'b0;
    send_beat(1'b0, 16'd65025, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.p_ready !== 1'b0 || bus.o_valid !== 1'b1 || bus.sum !== 24'd65025 || bus.terms !== 8'd1) begin
        errors++;
        $display("FAIL hold_cycle%0d: got p_ready=%b o_valid=%b sum=%0d terms=%0d expected 0 1 65025 1",
                 c, bus.p_ready, bus.o_valid, bus.sum, bus.terms);
      end
      tick();
    end
    bus.o_ready = 1'b1;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL hold_release_o_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.p_ready !== 1'b1) begin errors++; $display("FAIL hold_release_p_ready: got %b expected 1", bus.p_ready); end
  endtask

  task automatic test_sat17();
    b17.o_ready = 1'b1;
    send_beat(1'b1, 16'd65025, 1'b0);
    send_beat(1'b1, 16'd65025, 1'b0);
    checks++; if (b17.sat !== 1'b0) begin errors++; $display("FAIL sat17_mid_sat: got %b expected 0", b17.sat); end
    send_beat(1'b1, 16'd65025, 1'b1);
    checks++; if (b17.o_valid !== 1'b1) begin errors++; $display("FAIL sat17_o_valid: got %b expected 1", b17.o_valid); end
    checks++; if (b17.sum !== 17'd131071) begin errors++; $display("FAIL sat17_sum: got %0d expected 131071", b17.sum); end
    checks++; if (b17.sat !== 1'b1) begin errors++; $display("FAIL sat17_sat: got %b expected 1", b17.sat); end
    checks++; if (b17.terms !== 8'd3) begin errors++; $display("FAIL sat17_terms: got %0d expected 3", b17.terms); end
    tick();
  endtask

  task automatic test_long();
    bus.o_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send_beat(1'b0, 16'd65025, (i == 255) ? 1'b1 : 1'b0);
    end
    checks++; if (bus.sum !== 24'd16646400) begin errors++; $display("FAIL long_sum: got %0d expected 16646400", bus.sum); end
    checks++; if (bus.terms !== 8'd255) begin errors++; $display("FAIL long_terms: got %0d expected 255", bus.terms); end
    checks++; if (bus.sat !== 1'b0) begin errors++; $display("FAIL long_sat: got %b expected 0", bus.sat); end
    bus.o_ready = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    bus.o_ready = 1'b1;
    send_beat(1'b0, 16'd10, 1'b0);
    send_beat(1'b0, 16'd20, 1'b0);
    clear = 1'b1;
    bus.p_valid = 1'b1; bus.prod = 16'd999; bus.p_last = 1'b1;
    tick();
    clear = 1'b0;
    bus.p_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL clear_o_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.sum !== 24'd0 || bus.terms !== 8'd0) begin errors++; $display("FAIL clear_zero: got sum=%0d terms=%0d expected 0 0", bus.sum, bus.terms); end
    checks++; if (bus.p_ready !== 1'b1) begin errors++; $display("FAIL clear_p_ready: got %b expected 1", bus.p_ready); end
    send_beat(1'b0, 16'd5, 1'b1);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL clear_next_o_valid: got %b expected 1", bus.o_valid); end
    checks++; if (bus.sum !== 24'd5) begin errors++; $display("FAIL clear_next_sum: got %0d expected 5", bus.sum); end
    checks++; if (bus.terms !== 8'd1) begin errors++; $display("FAIL clear_next_terms: got %0d expected 1", bus.terms); end
    tick();
  endtask

  task automatic test_async_reset();
    bus.o_ready = 1'b0;
    send_beat(1'b0, 16'd7, 1'b0);
    send_beat(1'b0, 16'd8, 1'b1);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_o_valid: got %b expected 1", bus.o_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL areset_o_valid: got %b expected 0", bus.o_valid); end
    checks++;
    if (bus.sum !== 24'd0 || bus.terms !== 8'd0 || bus.sat !== 1'b0 || bus.p_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_outputs: got sum=%0d terms=%0d sat=%b p_ready=%b expected all 0",
               bus.sum, bus.terms, bus.sat, bus.p_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    bus.o_ready = 1'b1;
    send_beat(1'b0, 16'd1000, 1'b0);
    send_beat(1'b0, 16'd2000, 1'b1);
    checks++; if (bus.sum !== 24'd3000 || bus.terms !== 8'd2) begin errors++; $display("FAIL b2b_first: got sum=%0d terms=%0d expected 3000 2", bus.sum, bus.terms); end
    send_beat(1'b0, 16'd4, 1'b0);
    send_beat(1'b0, 16'd5, 1'b0);
    send_beat(1'b0, 16'd6, 1'b1);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_o_valid: got %b expected 1", bus.o_valid); end
    checks++; if (bus.sum !== 24'd15 || bus.terms !== 8'd3) begin errors++; $display("FAIL b2b_second: got sum=%0d terms=%0d expected 15 3", bus.sum, bus.terms); end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear  = 1'b0;
    bus.p_valid = 1'b0; bus.prod = 16'd0; bus.p_last = 1'b0; bus.o_ready = 1'b0;
    b17.p_valid = 1'b0; b17.prod = 16'd0; b17.p_last = 1'b0; b17.o_ready = 1'b1;
    test_reset();
    test_basic();
    test_hold();
    test_sat17();
    test_long();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
